// File: rtl/icache_pkg.sv
// icache_pkg: shared geometry, FSM state type and small helpers for the instruction cache.
package icache_pkg;
    localparam int INDEX_W  = 3;
    localparam int OFFSET_W = 2;
    localparam int ADDR_W   = 30;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINE_W   = 128;
    localparam int LADDR_W  = ADDR_W - OFFSET_W;
    localparam int LINES    = 1 << INDEX_W;

    typedef enum logic {COMPARE, ALLOCATE} state_e;

    function automatic logic [LADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:OFFSET_W];
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return &c ? c : c + 32'd1;
    endfunction
endpackage

// File: rtl/icache_if.sv
// icache_if: fetch-side and memory-side handshake bundle of the instruction cache.
interface icache_if;
    import icache_pkg::*;
    logic                proc_read;
    logic [ADDR_W-1:0]   proc_addr;
    logic [31:0]         proc_rdata;
    logic                proc_stall;
    logic                mem_read;
    logic [LADDR_W-1:0]  mem_addr;
    logic [LINE_W-1:0]   mem_rdata;
    logic                mem_ready;

    modport slave  (input proc_read, proc_addr, mem_rdata, mem_ready,
                    output proc_rdata, proc_stall, mem_read, mem_addr);
    modport master (output proc_read, proc_addr, mem_rdata, mem_ready,
                    input proc_rdata, proc_stall, mem_read, mem_addr);
endinterface

// File: rtl/icache_line_store.sv
// icache_line_store: valid/tag/data arrays with async read by index and one sync write port.
module icache_line_store
    import icache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [LINE_W-1:0]  wr_line,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_line
);
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    always_comb begin
        valid_d = valid_q;
        if (we) valid_d[wr_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= '0;
        else      valid_q <= valid_d;
    end

    // Tag/data storage carries no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];
endmodule

// File: rtl/instruction_cache.sv
// instruction_cache: read-only direct-mapped L1 I-cache, 0-cycle hits, single-line refill on miss.
module instruction_cache
    import icache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    icache_if.slave     bus,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    state_e             state_q, state_d;
    logic               mem_read_q, mem_read_d;
    logic [LADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]        hit_count_q, hit_count_d;
    logic [31:0]        miss_count_q, miss_count_d;
    logic               rd_valid, hit, fill_we;
    logic [TAG_W-1:0]   rd_tag;
    logic [LINE_W-1:0]  rd_line;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [OFFSET_W-1:0] req_off;

    assign req_tag = bus.proc_addr[ADDR_W-1 -: TAG_W];
    assign req_idx = bus.proc_addr[OFFSET_W +: INDEX_W];
    assign req_off = bus.proc_addr[OFFSET_W-1:0];
    assign hit     = rd_valid && (rd_tag == req_tag);

    icache_line_store u_store (
        .clk     (clk),
        .rst     (rst),
        .we      (fill_we),
        .wr_idx  (mem_addr_q[INDEX_W-1:0]),
        .wr_tag  (mem_addr_q[LADDR_W-1:INDEX_W]),
        .wr_line (bus.mem_rdata),
        .rd_idx  (req_idx),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_line (rd_line)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= COMPARE;
            mem_read_q   <= 1'b0;
            mem_addr_q   <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_read_q   <= mem_read_d;
            mem_addr_q   <= mem_addr_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_read_d   = mem_read_q;
        mem_addr_d   = mem_addr_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == COMPARE && bus.proc_read) begin
            if (hit) begin
                hit_count_d = sat_inc(hit_count_q);
            end else begin
                state_d      = ALLOCATE;
                mem_read_d   = 1'b1;
                mem_addr_d   = line_addr(bus.proc_addr);
                miss_count_d = sat_inc(miss_count_q);
            end
        end
        if (state_q == ALLOCATE && bus.mem_ready) begin
            state_d    = COMPARE;
            mem_read_d = 1'b0;
        end
    end

    // The indexed line is always muxed out; proc_stall tells fetch whether to use it.
    always_comb begin
        fill_we        = (state_q == ALLOCATE) && bus.mem_ready;
        bus.proc_stall = (state_q == ALLOCATE) || (bus.proc_read && !hit);
        bus.proc_rdata = rd_line[{req_off, 5'b0} +: 32];
    end

    assign bus.mem_read = mem_read_q;
    assign bus.mem_addr = mem_addr_q;
    assign hit_count    = hit_count_q;
    assign miss_count   = miss_count_q;
endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: directed checks of hits, misses, conflicts, stray ready and mid-refill reset.
module tb_instruction_cache;
    import icache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] hit_count, miss_count;
    int          tests = 0;
    int          errors = 0;

    icache_if bus ();

    instruction_cache dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word at address a is a*3 + 0x1000_0000, so expected words are easy to hand-compute.
    function automatic logic [127:0] mkline(input logic [LADDR_W-1:0] la);
        logic [127:0] l;
        for (int w = 0; w < 4; w++)
            l[w*32 +: 32] = {2'b00, la, 2'(w)} * 32'd3 + 32'h1000_0000;
        return l;
    endfunction

    task automatic refill(input logic [LADDR_W-1:0] la);
        int n = 0;
        while (!bus.mem_read && n < 20) begin
            tick();
            n++;
        end
        check("refill_req_seen", 32'(n < 20), 32'd1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mkline(la);
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    initial begin
        rst           = 1'b0;
        bus.proc_read = 1'b0;
        bus.proc_addr = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        #1;
        check("rst_mem_read", 32'(bus.mem_read), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_hits", hit_count, 32'd0);
        check("rst_misses", miss_count, 32'd0);
        check("rst_idle_stall", 32'(bus.proc_stall), 32'd0);
        tick();
        tick();
        rst = 1'b1;

        // Cold miss on 0x4, memory answers 3 cycles after mem_read rises.
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h4;
        #1;
        check("cold_stall", 32'(bus.proc_stall), 32'd1);
        tick();
        check("req_mem_read", 32'(bus.mem_read), 32'd1);
        check("req_mem_addr", 32'(bus.mem_addr), 32'h1);
        check("req_misses", miss_count, 32'd1);
        bus.proc_addr = 30'h4;
        tick();
        tick();
        check("wait_stall", 32'(bus.proc_stall), 32'd1);
        check("wait_mem_read", 32'(bus.mem_read), 32'd1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mkline(28'h1);
        tick();
        bus.mem_ready = 1'b0;
        check("fill_mem_read", 32'(bus.mem_read), 32'd0);
        check("fill_stall", 32'(bus.proc_stall), 32'd0);
        check("fill_rdata", bus.proc_rdata, 32'h1000_000C);
        check("fill_hits", hit_count, 32'd0);

        // Sequential hits on 0x4..0x7.
        for (int i = 0; i < 4; i++) begin
            bus.proc_addr = 30'(4 + i);
            #1;
            check("seq_stall", 32'(bus.proc_stall), 32'd0);
            check("seq_rdata", bus.proc_rdata, 32'h1000_000C + 32'(3 * i));
            tick();
        end
        check("seq_hits", hit_count, 32'd4);

        // Conflict on index 1: 0x24 evicts 0x4, which then misses again.
        bus.proc_addr = 30'h24;
        #1;
        check("conf_stall", 32'(bus.proc_stall), 32'd1);
        tick();
        check("conf_mem_addr", 32'(bus.mem_addr), 32'h9);
        refill(28'h9);
        check("conf_rdata", bus.proc_rdata, 32'h1000_006C);
        check("conf_misses", miss_count, 32'd2);
        bus.proc_addr = 30'h4;
        #1;
        check("evict_stall", 32'(bus.proc_stall), 32'd1);
        tick();
        check("evict_mem_addr", 32'(bus.mem_addr), 32'h1);
        refill(28'h1);
        check("evict_rdata", bus.proc_rdata, 32'h1000_000C);
        check("evict_misses", miss_count, 32'd3);

        // Address moved during refill: captured line 0x10 still fills, 0x4 stays resident.
        bus.proc_addr = 30'h40;
        #1;
        tick();
        check("move_mem_addr", 32'(bus.mem_addr), 32'h10);
        bus.proc_addr = 30'h4;
        #1;
        check("move_alloc_stall", 32'(bus.proc_stall), 32'd1);
        tick();
        check("move_addr_held", 32'(bus.mem_addr), 32'h10);
        refill(28'h10);
        check("move_hit_stall", 32'(bus.proc_stall), 32'd0);
        check("move_hit_rdata", bus.proc_rdata, 32'h1000_000C);
        bus.proc_addr = 30'h40;
        #1;
        check("move_fill_rdata", bus.proc_rdata, 32'h1000_00C0);

        // Stray mem_ready in COMPARE must not write the array.
        bus.mem_ready = 1'b1;
        bus.mem_rdata = '1;
        tick();
        bus.mem_ready = 1'b0;
        check("stray_stall", 32'(bus.proc_stall), 32'd0);
        check("stray_rdata", bus.proc_rdata, 32'h1000_00C0);
        check("stray_mem_read", 32'(bus.mem_read), 32'd0);
        check("stray_hits", hit_count, 32'd5);
        check("stray_misses", miss_count, 32'd4);

        // Reset mid-refill aborts the request and invalidates everything.
        bus.proc_addr = 30'h80;
        #1;
        tick();
        check("abort_pre_mem_read", 32'(bus.mem_read), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_mem_read", 32'(bus.mem_read), 32'd0);
        check("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("abort_hits", hit_count, 32'd0);
        check("abort_misses", miss_count, 32'd0);
        check("abort_stall", 32'(bus.proc_stall), 32'd1);
        tick();
        rst           = 1'b1;
        bus.proc_read = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mkline(28'h20);
        tick();
        bus.mem_ready = 1'b0;
        check("late_mem_read", 32'(bus.mem_read), 32'd0);
        check("late_misses", miss_count, 32'd0);
        bus.proc_read = 1'b1;
        #1;
        check("late_no_write", 32'(bus.proc_stall), 32'd1);
        bus.proc_addr = 30'h4;
        #1;
        check("late_invalid", 32'(bus.proc_stall), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
